// File: rtl/ahb_lite_decode_mux_if.sv
// rtl/ahb_lite_decode_mux_if.sv - AHB-Lite decoder/mux bus bundle
//
// Groups the master-facing and slave-facing AHB-Lite signals of the decoder.
//   slave  modport : decoder view (takes address/slave responses, drives HREADY/HRDATA/HRESP/HSEL_S)
//   master modport : environment view (drives address and slave responses)
//   HADDR[31:0], HTRANS[1:0]          master address phase
//   HREADY, HRDATA[31:0], HRESP       muxed data-phase response to master
//   HSEL_S[3:0]                       per-slave select
//   HREADYOUT_S[3:0], HRDATA_S[127:0], HRESP_S[3:0]  per-slave responses
interface ahb_lite_decode_mux_if;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HREADY;
    logic [31:0]  HRDATA;
    logic         HRESP;
    logic [3:0]   HSEL_S;
    logic [3:0]   HREADYOUT_S;
    logic [127:0] HRDATA_S;
    logic [3:0]   HRESP_S;

    modport slave (
        input  HADDR, HTRANS, HREADYOUT_S, HRDATA_S, HRESP_S,
        output HREADY, HRDATA, HRESP, HSEL_S
    );

    modport master (
        output HADDR, HTRANS, HREADYOUT_S, HRDATA_S, HRESP_S,
        input  HREADY, HRDATA, HRESP, HSEL_S
    );
endinterface

// File: rtl/ahb_lite_decode_mux.sv
// rtl/ahb_lite_decode_mux.sv - AHB-Lite 4-slave address decoder and response mux
//
// Decodes HADDR into a one-hot HSEL_S (lowest index wins on overlap), registers
// the select for the data phase, and muxes the selected slave's response back to
// the master. Unmapped addresses go to an internal default slave that answers
// active transfers with a two-cycle ERROR and idle/busy transfers with OKAY.
//   HCLK     clock
//   HRESETn  asynchronous active-low reset
//   bus      ahb_lite_decode_mux_if.slave (HADDR, HTRANS, HREADY, HRDATA, HRESP,
//            HSEL_S, HREADYOUT_S, HRDATA_S, HRESP_S)
module ahb_lite_decode_mux #(
    parameter logic [31:0] BASE0 = 32'h0000_0000,
    parameter logic [31:0] MASK0 = 32'hFFFF_0000,
    parameter logic [31:0] BASE1 = 32'h1000_0000,
    parameter logic [31:0] MASK1 = 32'hFFFF_0000,
    parameter logic [31:0] BASE2 = 32'h2000_0000,
    parameter logic [31:0] MASK2 = 32'hFFFF_0000,
    parameter logic [31:0] BASE3 = 32'h4000_0000,
    parameter logic [31:0] MASK3 = 32'hF000_0000
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_decode_mux_if.slave  bus
);

    typedef enum logic [1:0] {
        DS_OK   = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // dsel bit 4 is the default slave; bits 3:0 mirror HSEL_S
    localparam logic [4:0] DSEL_DEF = 5'b1_0000;

    logic [3:0]  dec_sel;
    logic        dec_def;
    logic        trans_active;
    logic [4:0]  dsel_q, dsel_d;
    ds_state_e   ds_state_q, ds_state_d;
    logic        ds_ready;
    logic        ds_resp;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    // Priority chain makes overlapping windows resolve to the lowest index.
    always_comb begin
        dec_sel = 4'b0000;
        if ((bus.HADDR & MASK0) == BASE0) begin
            dec_sel = 4'b0001;
        end else if ((bus.HADDR & MASK1) == BASE1) begin
            dec_sel = 4'b0010;
        end else if ((bus.HADDR & MASK2) == BASE2) begin
            dec_sel = 4'b0100;
        end else if ((bus.HADDR & MASK3) == BASE3) begin
            dec_sel = 4'b1000;
        end
    end

    assign dec_def      = (dec_sel == 4'b0000);
    assign trans_active = bus.HTRANS[1];  // NONSEQ or SEQ

    assign dsel_d = hready ? {dec_def, dec_sel} : dsel_q;

    // Default-slave response, a function of state only so the HREADY feedback
    // into the next-state logic below is not a combinational loop.
    always_comb begin
        ds_ready = 1'b1;
        ds_resp  = 1'b0;
        case (ds_state_q)
            DS_ERR1: begin
                ds_ready = 1'b0;
                ds_resp  = 1'b1;
            end
            DS_ERR2: begin
                ds_ready = 1'b1;
                ds_resp  = 1'b1;
            end
            default: begin
                ds_ready = 1'b1;
                ds_resp  = 1'b0;
            end
        endcase
    end

    always_comb begin
        ds_state_d = ds_state_q;
        case (ds_state_q)
            DS_OK: begin
                if (hready && dec_def && trans_active) begin
                    ds_state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                ds_state_d = DS_ERR2;
            end
            DS_ERR2: begin
                if (hready && dec_def && trans_active) begin
                    ds_state_d = DS_ERR1;
                end else begin
                    ds_state_d = DS_OK;
                end
            end
            default: begin
                ds_state_d = DS_OK;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q     <= DSEL_DEF;
            ds_state_q <= DS_OK;
        end else begin
            dsel_q     <= dsel_d;
            ds_state_q <= ds_state_d;
        end
    end

    always_comb begin
        hready = ds_ready;
        hresp  = ds_resp;
        hrdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (dsel_q[i]) begin
                hready = bus.HREADYOUT_S[i];
                hresp  = bus.HRESP_S[i];
                hrdata = bus.HRDATA_S[32*i +: 32];
            end
        end
    end

    assign bus.HSEL_S = dec_sel;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = hrdata;

endmodule

// File: tb/tb_ahb_lite_decode_mux.sv
// tb/tb_ahb_lite_decode_mux.sv - self-checking bench for ahb_lite_decode_mux
module tb_ahb_lite_decode_mux;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] m_base [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000};
    logic [31:0] m_mask [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};

    ahb_lite_decode_mux_if bus ();

    ahb_lite_decode_mux dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    function automatic int decode_idx(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return 4;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        bus.HADDR = 32'h0;
        bus.HTRANS = 2'b00;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.HSEL_S} !== {1'b1, 1'b0, 32'h0, 4'b0001}) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", {bus.HREADY, bus.HRESP, bus.HRDATA, bus.HSEL_S}, {1'b1, 1'b0, 32'h0, 4'b0001});
        end
        tick();
        HRESETn = 1'b1;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.HSEL_S} !== {1'b1, 1'b0, 32'h0, 4'b0001}) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", {bus.HREADY, bus.HRESP, bus.HRDATA, bus.HSEL_S}, {1'b1, 1'b0, 32'h0, 4'b0001});
        end
        tick();
    endtask

    task automatic test_slave0_wait();
        bus.HADDR = 32'h0000_0010;
        bus.HTRANS = 2'b10;
        bus.HREADYOUT_S = 4'hF;
        @(negedge HCLK);
        n_checks++;
        if (bus.HSEL_S !== 4'b0001) begin
            n_fail++;
            $display("FAIL s0_addr_hsel: got %b want 0001", bus.HSEL_S);
        end
        tick();
        bus.HTRANS = 2'b00;
        bus.HREADYOUT_S[0] = 1'b0;
        bus.HRDATA_S[31:0] = 32'hCAFE_0001;
        @(negedge HCLK);
        n_checks++;
        if (bus.HREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL s0_wait: HREADY got %b want 0", bus.HREADY);
        end
        tick();
        bus.HREADYOUT_S[0] = 1'b1;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
            n_fail++;
            $display("FAIL s0_data: got %h want %h", {bus.HREADY, bus.HRESP, bus.HRDATA}, {1'b1, 1'b0, 32'hCAFE_0001});
        end
        tick();
    endtask

    task automatic test_stall_switch();
        bus.HADDR = 32'h0000_0004;
        bus.HTRANS = 2'b10;
        bus.HREADYOUT_S = 4'hF;
        tick();
        bus.HADDR = 32'h1000_0000;
        bus.HREADYOUT_S[0] = 1'b0;
        bus.HRDATA_S[31:0] = 32'hA0A0_0000;
        bus.HRDATA_S[63:32] = 32'hB1B1_0001;
        for (int c = 0; c < 2; c++) begin
            @(negedge HCLK);
            n_checks++;
            if ({bus.HREADY, bus.HRDATA, bus.HSEL_S} !== {1'b0, 32'hA0A0_0000, 4'b0010}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h want %h", c, {bus.HREADY, bus.HRDATA, bus.HSEL_S}, {1'b0, 32'hA0A0_0000, 4'b0010});
            end
            tick();
        end
        bus.HREADYOUT_S[0] = 1'b1;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRDATA} !== {1'b1, 32'hA0A0_0000}) begin
            n_fail++;
            $display("FAIL stall_release: got %h want %h", {bus.HREADY, bus.HRDATA}, {1'b1, 32'hA0A0_0000});
        end
        tick();
        bus.HTRANS = 2'b00;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRDATA} !== {1'b1, 32'hB1B1_0001}) begin
            n_fail++;
            $display("FAIL switch_s1: got %h want %h", {bus.HREADY, bus.HRDATA}, {1'b1, 32'hB1B1_0001});
        end
        tick();
    endtask

    task automatic test_unmapped();
        bus.HADDR = 32'h8000_0000;
        bus.HTRANS = 2'b10;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HSEL_S} !== {1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL unm_addr: got %h want %h", {bus.HREADY, bus.HSEL_S}, {1'b1, 4'b0000});
        end
        tick();
        bus.HTRANS = 2'b00;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRESP, bus.HRDATA} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL unm_err1: got %h want %h", {bus.HREADY, bus.HRESP, bus.HRDATA}, {1'b0, 1'b1, 32'h0});
        end
        tick();
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRESP} !== 2'b11) begin
            n_fail++;
            $display("FAIL unm_err2: got %b want 11", {bus.HREADY, bus.HRESP});
        end
        tick();
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL unm_idle_ok: got %h want %h", {bus.HREADY, bus.HRESP, bus.HRDATA}, {1'b1, 1'b0, 32'h0});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_seq [4] = '{2'b01, 2'b11, 2'b01, 2'b11};
        bus.HADDR = 32'h3000_0000;
        bus.HTRANS = 2'b10;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) bus.HTRANS = 2'b00;
            @(negedge HCLK);
            n_checks++;
            if ({bus.HREADY, bus.HRESP} !== exp_seq[c]) begin
                n_fail++;
                $display("FAIL b2b_err%0d: got %b want %b", c, {bus.HREADY, bus.HRESP}, exp_seq[c]);
            end
            tick();
        end
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRESP} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_ok: got %b want 10", {bus.HREADY, bus.HRESP});
        end
        tick();
    endtask

    task automatic test_reset_mid_err();
        bus.HADDR = 32'h8000_0000;
        bus.HTRANS = 2'b10;
        tick();
        bus.HTRANS = 2'b00;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRESP} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_pre_err1: got %b want 01", {bus.HREADY, bus.HRESP});
        end
        #1;
        HRESETn = 1'b0;
        #1;
        n_checks++;
        if ({bus.HREADY, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_async: got %h want %h", {bus.HREADY, bus.HRESP, bus.HRDATA}, {1'b1, 1'b0, 32'h0});
        end
        tick();
        HRESETn = 1'b1;
        bus.HADDR = 32'h4123_0000;
        bus.HTRANS = 2'b10;
        bus.HREADYOUT_S = 4'hF;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HSEL_S} !== {1'b1, 4'b1000}) begin
            n_fail++;
            $display("FAIL rst_s3_addr: got %h want %h", {bus.HREADY, bus.HSEL_S}, {1'b1, 4'b1000});
        end
        tick();
        bus.HTRANS = 2'b00;
        bus.HRDATA_S[127:96] = 32'hD00D_0003;
        bus.HRESP_S = 4'b0000;
        @(negedge HCLK);
        n_checks++;
        if ({bus.HREADY, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 32'hD00D_0003}) begin
            n_fail++;
            $display("FAIL rst_s3_data: got %h want %h", {bus.HREADY, bus.HRESP, bus.HRDATA}, {1'b1, 1'b0, 32'hD00D_0003});
        end
        tick();
    endtask

    // Model: one data phase per accepted address phase; the owner is the slave
    // decoded when the master saw HREADY high. A default-slave active transfer
    // answers "wait+ERROR" in its first cycle and "ready+ERROR" in its second.
    task automatic test_random();
        int          owner;
        int          nxt;
        int          def_cyc;
        bit          def_act;
        logic        exp_rdy;
        logic        exp_rsp;
        logic [31:0] exp_rd;
        logic [3:0]  exp_sel;
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        owner   = 4;
        def_act = 1'b0;
        def_cyc = 0;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0:       bus.HADDR = {16'h0000, 16'($urandom)};
                1:       bus.HADDR = {16'h1000, 16'($urandom)};
                2:       bus.HADDR = {16'h2000, 16'($urandom)};
                3:       bus.HADDR = {4'h4, 28'($urandom)};
                default: bus.HADDR = $urandom;
            endcase
            bus.HTRANS = 2'($urandom);
            for (int i = 0; i < 4; i++) bus.HREADYOUT_S[i] = ($urandom_range(0, 3) != 0);
            bus.HRDATA_S = {$urandom, $urandom, $urandom, $urandom};
            bus.HRESP_S  = 4'($urandom);
            nxt     = decode_idx(bus.HADDR);
            exp_sel = (nxt < 4) ? 4'(1 << nxt) : 4'b0000;
            if (owner < 4) begin
                exp_rdy = bus.HREADYOUT_S[owner];
                exp_rsp = bus.HRESP_S[owner];
                exp_rd  = bus.HRDATA_S[32*owner +: 32];
            end else begin
                exp_rdy = !(def_act && def_cyc == 0);
                exp_rsp = def_act;
                exp_rd  = 32'h0;
            end
            @(negedge HCLK);
            n_checks++;
            if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.HSEL_S} !== {exp_rdy, exp_rsp, exp_rd, exp_sel}) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: got %h want %h (addr %h trans %b owner %0d)", c,
                         {bus.HREADY, bus.HRESP, bus.HRDATA, bus.HSEL_S}, {exp_rdy, exp_rsp, exp_rd, exp_sel},
                         bus.HADDR, bus.HTRANS, owner);
            end
            @(posedge HCLK);
            if (exp_rdy) begin
                owner   = nxt;
                def_act = (nxt == 4) && bus.HTRANS[1];
                def_cyc = 0;
            end else begin
                def_cyc++;
            end
            #1;
        end
    endtask

    initial begin
        HRESETn         = 1'b0;
        bus.HADDR       = 32'h0;
        bus.HTRANS      = 2'b00;
        bus.HREADYOUT_S = 4'hF;
        bus.HRDATA_S    = '0;
        bus.HRESP_S     = 4'b0000;
        test_reset();
        test_slave0_wait();
        test_stall_switch();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_decode_mux.md
Name: ahb_lite_decode_mux

Overview:
- AHB-Lite single-master address decoder and slave response multiplexer for up to 4 slaves.
- Sits directly upstream of ahb_to_ssram and the other AHB slaves.
  - Drives each slave's HSEL from the address phase.
  - Muxes slave HREADYOUT/HRDATA/HRESP back to the master in the data phase.
- Contains an internal default slave that answers unmapped active transfers with a two-cycle ERROR response.

Parameters:
- BASE0, 32'h0000_0000, slave 0 base address (SSRAM)
- MASK0, 32'hFFFF_0000, slave 0 compare mask
- BASE1, 32'h1000_0000, slave 1 base address
- MASK1, 32'hFFFF_0000, slave 1 compare mask
- BASE2, 32'h2000_0000, slave 2 base address
- MASK2, 32'hFFFF_0000, slave 2 compare mask
- BASE3, 32'h4000_0000, slave 3 base address
- MASK3, 32'hF000_0000, slave 3 compare mask

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type
- HREADY  out  1  bus ready, to master and to all slaves' HREADY inputs
- HRDATA  out  32  read data to master
- HRESP  out  1  response to master (0 = OKAY, 1 = ERROR)
- HSEL_S  out  4  per-slave select, bit i = slave i
- HREADYOUT_S  in  4  per-slave HREADYOUT
- HRDATA_S  in  128  per-slave read data, slave i on bits [32*i+31:32*i]
- HRESP_S  in  4  per-slave HRESP

Behaviour:
- Reset/clock: HRESETn asynchronous, active-low; clock HCLK. All flops async-reset.
- Decode (combinational, address phase):
  - Slave i matches when (HADDR & MASKi) == BASEi.
  - Overlapping matches: the lowest index wins, so HSEL_S is always one-hot or zero.
  - No match: default slave selected internally, HSEL_S = 4'b0000.
  - HSEL_S is not gated by HTRANS or HREADY; slaves qualify with HTRANS and HREADY themselves.
- Data-phase select register dsel_r (5 bits one-hot: S0..S3, DEF):
  - Loaded with the decoded select on every rising HCLK where HREADY = 1.
  - Held while HREADY = 0.
  - Reset value: DEF.
- Output mux, driven from dsel_r:
  - dsel_r = Si: HREADY = HREADYOUT_S[i], HRDATA = HRDATA_S slice i, HRESP = HRESP_S[i].
  - dsel_r = DEF: HRDATA = 32'h0; HREADY and HRESP come from the default-slave FSM.
- Default-slave FSM, states DS_OK, DS_ERR1, DS_ERR2; reset state DS_OK.
  - DS_OK: drives ready = 1, resp = 0.
    - Goes to DS_ERR1 when HREADY = 1, the decode selects DEF, and HTRANS is NONSEQ (2'b10) or SEQ (2'b11).
    - IDLE (2'b00) and BUSY (2'b01) to DEF get a zero-wait OKAY and stay in DS_OK.
  - DS_ERR1: drives ready = 0, resp = 1. Unconditionally goes to DS_ERR2.
  - DS_ERR2: drives ready = 1, resp = 1.
    - Goes to DS_ERR1 if another active DEF transfer is presented (HREADY = 1 here).
    - Otherwise goes to DS_OK.
- Latency:
  - Zero added cycles; decode and mux are combinational.
  - Wait states come only from the selected slave, or from the fixed single DS_ERR1 cycle.
- Boundary conditions:
  - Address phase to slave j while the data phase of slave i stalls: dsel_r keeps i until the master sees HREADY = 1.
  - Back-to-back unmapped NONSEQs: ERROR, ERROR, each taking 2 cycles.
  - Unmapped IDLE immediately after a slave transfer: dsel_r = DEF, HREADY = 1, HRESP = 0, HRDATA = 0.
  - Reset mid-transfer: dsel_r = DEF and FSM = DS_OK immediately.
- Output values during reset: HREADY = 1, HRESP = 0, HRDATA = 32'h0, HSEL_S = decode of HADDR (combinational).

Test Plan:
- Reset release, HTRANS = IDLE, HADDR = 0 -> HREADY = 1, HRESP = 0, HRDATA = 0, HSEL_S = 4'b0001.
- NONSEQ read at 32'h0000_0010, slave 0 returns HRDATA_S[31:0] = 32'hCAFE_0001 with one wait state -> HSEL_S = 0001 in the address cycle; HREADY = 0 then 1; HRDATA = 32'hCAFE_0001; HRESP = 0.
- NONSEQ at 32'h0000_0004 followed by NONSEQ at 32'h1000_0000 while slave 0 holds HREADYOUT low 2 cycles -> dsel_r stays S0 through the stall; HRDATA switches to the slave 1 slice only after HREADY = 1.
- NONSEQ to unmapped 32'h8000_0000 -> cycle 1: HREADY = 0, HRESP = 1; cycle 2: HREADY = 1, HRESP = 1; then OKAY. IDLE to the same address -> HREADY = 1, HRESP = 0.
- Two back-to-back NONSEQs to 32'h3000_0000 -> ERR1, ERR2, ERR1, ERR2, then DS_OK; HRESP high for 4 cycles.
- HRESETn asserted during DS_ERR1 -> HREADY = 1 and HRESP = 0 asynchronously; after release, a slave 3 access at 32'h4123_0000 selects HSEL_S = 4'b1000.
